// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch/countdown timer: state encoding,
// BCD digit limits and display-width helper.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned BCD_W        = 4;
   localparam logic [3:0]  TENTH_MAX    = 4'd9;
   localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
   localparam logic [3:0]  SEC_ONES_MAX = 4'd9;

   // Width of the packed {min, sec_tens, sec_ones, tenth} display word.
   function automatic int unsigned fnd_width(input int unsigned min_digits);
      return BCD_W * min_digits + 3 * BCD_W;
   endfunction

   // Largest legal value of packed digit idx (0 = tenths, 2 = seconds tens).
   function automatic logic [3:0] digit_max(input int unsigned idx);
      if (idx == 0)      return TENTH_MAX;
      else if (idx == 2) return SEC_TENS_MAX;
      else               return SEC_ONES_MAX;
   endfunction

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
      return (d > mx) ? mx : d;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks while enabled.
// Disabling clears the count so a restart always waits a full period.
module tick_gen #(
   parameter int unsigned TICK_DIV = 10
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic enable,
   output logic tick
);

   localparam int unsigned   CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   // Count 0..TICK_DIV-1 while enabled, hold at zero otherwise.
   always_ff @(posedge i_clk) begin
      if (i_reset || !enable)  cnt <= '0;
      else if (cnt == LAST)    cnt <= '0;
      else                     cnt <= cnt + 1'b1;
   end

   assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/stopwatch_timer_core.sv
// BCD stopwatch / countdown timer with run/pause/done control.
// Optional lap-hold display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_timer_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned TICK_HZ    = 10,
   parameter int unsigned MIN_DIGITS = 1
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_runstop,
   input  logic                          i_clear,
   input  logic                          i_mode,
   input  logic [4*MIN_DIGITS-1:0]       i_preset_min,
   input  logic [7:0]                    i_preset_sec,
   output logic [4*MIN_DIGITS+12-1:0]    o_fndcnt,
   output logic                          o_running,
   output logic                          o_done,
   output logic                          o_wrap
`ifdef STOPWATCH_LAP_EN
   ,
   input  logic                          i_lap,
   output logic                          o_lap_active
`endif
);

   localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned FW       = fnd_width(MIN_DIGITS);
   localparam int unsigned MW       = BCD_W * MIN_DIGITS;
   localparam int unsigned NDIG     = MIN_DIGITS + 3;

   state_t          state_q, state_d;
   logic            mode_q, mode_d;
   logic [FW-1:0]   cnt_q, cnt_d;
   logic [FW-1:0]   fnd_q, disp_d;
   logic            wrap_q, wrap_d;
   logic            tick;
   logic [FW-1:0]   cnt_inc, cnt_dec, preset_cnt;
   logic [MW-1:0]   preset_min_s;
   logic            carry, borrow, inc_wrap;

`ifdef STOPWATCH_LAP_EN
   logic            lap_act_q, lap_act_d;
   logic [FW-1:0]   lap_q, lap_d;
`endif

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .enable  (state_q == RUN),
      .tick    (tick)
   );

   // Sanitise the countdown preset into a legal BCD reload word.
   always_comb begin
      preset_min_s = '0;
      for (int unsigned i = 0; i < MIN_DIGITS; i++)
         preset_min_s[i*BCD_W +: BCD_W] = clamp_digit(i_preset_min[i*BCD_W +: BCD_W], SEC_ONES_MAX);
      preset_cnt = {preset_min_s,
                    clamp_digit(i_preset_sec[7:4], SEC_TENS_MAX),
                    clamp_digit(i_preset_sec[3:0], SEC_ONES_MAX),
                    4'd0};
   end

   // Ripple carry / borrow through the digit chain, each digit with its own limit.
   always_comb begin
      cnt_inc = cnt_q;
      cnt_dec = cnt_q;
      carry   = 1'b1;
      borrow  = 1'b1;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (carry) begin
            if (cnt_q[i*BCD_W +: BCD_W] == digit_max(i)) begin
               cnt_inc[i*BCD_W +: BCD_W] = '0;
            end else begin
               cnt_inc[i*BCD_W +: BCD_W] = cnt_q[i*BCD_W +: BCD_W] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (cnt_q[i*BCD_W +: BCD_W] == 4'd0) begin
               cnt_dec[i*BCD_W +: BCD_W] = digit_max(i);
            end else begin
               cnt_dec[i*BCD_W +: BCD_W] = cnt_q[i*BCD_W +: BCD_W] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
      inc_wrap = carry;
   end

   // Next state, mode, count and display selection.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      if (i_clear) begin
         state_d = IDLE;
         cnt_d   = mode_q ? preset_cnt : '0;
      end else begin
         case (state_q)
            IDLE: begin
               mode_d = i_mode;
               cnt_d  = i_mode ? preset_cnt : '0;
               if (i_runstop && !(i_mode && (preset_cnt == '0)))
                  state_d = RUN;
            end
            RUN: begin
               if (!i_runstop) begin
                  state_d = PAUSE;
               end else if (tick) begin
                  if (mode_q) begin
                     cnt_d = cnt_dec;
                     if (cnt_dec == '0) state_d = DONE;
                  end else begin
                     cnt_d  = cnt_inc;
                     wrap_d = inc_wrap;
                  end
               end
            end
            PAUSE: begin
               if (i_runstop) state_d = RUN;
            end
            DONE: ;
            default: state_d = IDLE;
         endcase
      end

      disp_d = cnt_d;
`ifdef STOPWATCH_LAP_EN
      lap_act_d = lap_act_q;
      lap_d     = lap_q;
      if (i_lap && (state_q == RUN || state_q == PAUSE)) begin
         if (!lap_act_q) begin
            lap_act_d = 1'b1;
            lap_d     = cnt_q;
         end else begin
            lap_act_d = 1'b0;
         end
      end
      if (i_clear || state_d == DONE || state_d == IDLE) lap_act_d = 1'b0;
      if (lap_act_d) disp_d = lap_d;
`endif
   end

   // State, count and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
         fnd_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         fnd_q   <= disp_d;
         wrap_q  <= wrap_d;
      end
   end

`ifdef STOPWATCH_LAP_EN
   // Lap-hold register and flag.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         lap_act_q <= 1'b0;
         lap_q     <= '0;
      end else begin
         lap_act_q <= lap_act_d;
         lap_q     <= lap_d;
      end
   end

   assign o_lap_active = lap_act_q;
`endif

   assign o_fndcnt  = fnd_q;
   assign o_wrap    = wrap_q;
   assign o_running = (state_q == RUN);
   assign o_done    = (state_q == DONE);

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Scoreboard bench for stopwatch_timer_core (CLK_HZ=100, TICK_HZ=10, MIN_DIGITS=1).
// Lap checks are included when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_timer_core;

   logic        clk = 1'b0;
   logic        i_reset, i_runstop, i_clear, i_mode;
   logic [3:0]  i_preset_min;
   logic [7:0]  i_preset_sec;
   logic [15:0] o_fndcnt;
   logic        o_running, o_done, o_wrap;
   logic        lap_obs;
`ifdef STOPWATCH_LAP_EN
   logic        i_lap;
   logic        o_lap_active;
   assign lap_obs = o_lap_active;
`else
   assign lap_obs = 1'b0;
`endif

   typedef struct {
      int unsigned cyc;
      string       name;
      logic [15:0] fnd;
      logic        run;
      logic        done;
      logic        wrap;
      logic        lap;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        e;
   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail  = 0;

   stopwatch_timer_core #(.CLK_HZ(100), .TICK_HZ(10), .MIN_DIGITS(1)) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_runstop    (i_runstop),
      .i_clear      (i_clear),
      .i_mode       (i_mode),
      .i_preset_min (i_preset_min),
      .i_preset_sec (i_preset_sec),
      .o_fndcnt     (o_fndcnt),
      .o_running    (o_running),
      .o_done       (o_done),
      .o_wrap       (o_wrap)
`ifdef STOPWATCH_LAP_EN
      ,
      .i_lap        (i_lap),
      .o_lap_active (o_lap_active)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Monitor: compare outputs against every expectation due this cycle.
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         e = sb_q.pop_front();
         n_tests++;
         if (e.cyc != cyc || o_fndcnt !== e.fnd || o_running !== e.run ||
             o_done !== e.done || o_wrap !== e.wrap || lap_obs !== e.lap) begin
            n_fail++;
            $display("FAIL %s: got cyc=%0d fnd=%h run=%b done=%b wrap=%b lap=%b, want cyc=%0d fnd=%h run=%b done=%b wrap=%b lap=%b",
                     e.name, cyc, o_fndcnt, o_running, o_done, o_wrap, lap_obs,
                     e.cyc, e.fnd, e.run, e.done, e.wrap, e.lap);
         end
      end
   end

   task automatic clk_n(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input string name, input logic [15:0] fnd, input logic run,
                           input logic done, input logic wrap, input logic lap = 1'b0);
      exp_t x;
      x.cyc = cyc; x.name = name; x.fnd = fnd;
      x.run = run; x.done = done; x.wrap = wrap; x.lap = lap;
      sb_q.push_back(x);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got cyc=%0d, want finish before 1ms", cyc);
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      i_reset = 1'b1; i_runstop = 1'b0; i_clear = 1'b0; i_mode = 1'b0;
      i_preset_min = 4'h0; i_preset_sec = 8'h00;
`ifdef STOPWATCH_LAP_EN
      i_lap = 1'b0;
`endif
      clk_n(2);
      push_exp("reset", 16'h0000, 0, 0, 0);
      i_reset = 1'b0;

      // Up count, first tick latency, 0:59.8 -> 1:00.0, then 9:59.9 wrap.
      i_runstop = 1'b1;
      clk_n(1);  push_exp("start_run", 16'h0000, 1, 0, 0);
      clk_n(9);  push_exp("pre_first_tick", 16'h0000, 1, 0, 0);
      clk_n(1);  push_exp("first_tick", 16'h0001, 1, 0, 0);
      clk_n(5970); push_exp("up_0598", 16'h0598, 1, 0, 0);
      clk_n(10); push_exp("up_0599", 16'h0599, 1, 0, 0);
      clk_n(10); push_exp("up_1000", 16'h1000, 1, 0, 0);
      clk_n(53990); push_exp("up_9599", 16'h9599, 1, 0, 0);
      clk_n(10); push_exp("wrap_pulse", 16'h0000, 1, 0, 1);
      clk_n(1);  push_exp("wrap_one_cycle", 16'h0000, 1, 0, 0);

      // Countdown from 0:02 to DONE, hold, then clear back to preset.
      i_runstop = 1'b0;
      clk_n(1);  push_exp("pause_after_wrap", 16'h0000, 0, 0, 0);
      i_clear = 1'b1;
      clk_n(1);  push_exp("clear_up", 16'h0000, 0, 0, 0);
      i_clear = 1'b0; i_mode = 1'b1; i_preset_min = 4'h0; i_preset_sec = 8'h02;
      clk_n(1);  push_exp("idle_tracks_preset", 16'h0020, 0, 0, 0);
      i_runstop = 1'b1;
      clk_n(1);  push_exp("down_start", 16'h0020, 1, 0, 0);
      clk_n(10); push_exp("down_0019", 16'h0019, 1, 0, 0);
      clk_n(189); push_exp("down_0001", 16'h0001, 1, 0, 0);
      clk_n(1);  push_exp("down_done", 16'h0000, 0, 1, 0);
      clk_n(100); push_exp("done_holds", 16'h0000, 0, 1, 0);
      i_clear = 1'b1;
      clk_n(1);  push_exp("done_clear", 16'h0020, 0, 0, 0);
      i_clear = 1'b0; i_runstop = 1'b0;

      // Zero preset in down mode refuses to start; preset digits clamp.
      i_preset_sec = 8'h00; i_runstop = 1'b1;
      clk_n(2);  push_exp("zero_preset_idle", 16'h0000, 0, 0, 0);
      i_runstop = 1'b0; i_preset_min = 4'hC; i_preset_sec = 8'hF7;
      clk_n(1);  push_exp("preset_clamp", 16'h9570, 0, 0, 0);

      // Pause holds; resume ticks a full period later; tick dropped on stop.
      i_mode = 1'b0;
      clk_n(1);  push_exp("idle_up_reload", 16'h0000, 0, 0, 0);
      i_runstop = 1'b1;
      clk_n(1);  push_exp("run_again", 16'h0000, 1, 0, 0);
      clk_n(50); push_exp("up_0005", 16'h0005, 1, 0, 0);
      i_runstop = 1'b0;
      clk_n(300); push_exp("pause_hold", 16'h0005, 0, 0, 0);
      i_runstop = 1'b1;
      clk_n(1);  push_exp("resume", 16'h0005, 1, 0, 0);
      clk_n(9);  push_exp("resume_pre_tick", 16'h0005, 1, 0, 0);
      clk_n(1);  push_exp("resume_tick", 16'h0006, 1, 0, 0);
      clk_n(9);
      i_runstop = 1'b0;
      clk_n(1);  push_exp("tick_dropped_on_stop", 16'h0006, 0, 0, 0);

      // Reset mid-count; clear coinciding with a tick.
      i_clear = 1'b1;
      clk_n(1);  push_exp("clear_pause", 16'h0000, 0, 0, 0);
      i_clear = 1'b0; i_runstop = 1'b1;
      clk_n(1);
      clk_n(340); push_exp("up_0034", 16'h0034, 1, 0, 0);
      i_reset = 1'b1;
      clk_n(1);  push_exp("reset_mid", 16'h0000, 0, 0, 0);
      i_reset = 1'b0;
      clk_n(1);  push_exp("run_after_reset", 16'h0000, 1, 0, 0);
      clk_n(10); push_exp("up_0001", 16'h0001, 1, 0, 0);
      clk_n(9);
      i_clear = 1'b1;
      clk_n(1);  push_exp("clear_beats_tick", 16'h0000, 0, 0, 0);
      i_clear = 1'b0;

`ifdef STOPWATCH_LAP_EN
      // Lap hold while counting continues, then release.
      clk_n(1);  push_exp("lap_run", 16'h0000, 1, 0, 0);
      clk_n(120); push_exp("lap_0012", 16'h0012, 1, 0, 0);
      i_lap = 1'b1;
      clk_n(1);  push_exp("lap_capture", 16'h0012, 1, 0, 0, 1'b1);
      i_lap = 1'b0;
      clk_n(148); push_exp("lap_holding", 16'h0012, 1, 0, 0, 1'b1);
      i_lap = 1'b1;
      clk_n(1);  push_exp("lap_release", 16'h0027, 1, 0, 0, 1'b0);
      i_lap = 1'b0;
`endif

      clk_n(2);
      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_timer_core.md
Name: stopwatch_timer_core

Overview:
Parametrised BCD stopwatch/countdown timer, the successor to the fixed 10 Hz stopwatch counter. It runs on the system clock and generates its own tenth-second tick. It supports up-count and countdown with preset, and has an explicit run/pause/done state machine. It drives the FND display path with packed BCD digits (minutes, seconds, tenths) instead of a binary sum.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz.
TICK_HZ, 10, count resolution. 10 gives tenths of a second. TICK_DIV = CLK_HZ/TICK_HZ, which must be at least 2.
MIN_DIGITS, 1, number of BCD minute digits. Minute range is 0 .. 10^MIN_DIGITS-1.

Ports:
i_clk  in  1  system clock, rising edge.
i_reset  in  1  synchronous, active-high reset.
i_runstop  in  1  level input: 1 = run, 0 = pause.
i_clear  in  1  one-cycle pulse. Returns to IDLE and reloads the count.
i_mode  in  1  0 = count up, 1 = count down. Sampled only in IDLE.
i_preset_min  in  4*MIN_DIGITS  BCD countdown preset, minutes.
i_preset_sec  in  8  BCD countdown preset, seconds: [7:4] tens, [3:0] ones.
o_fndcnt  out  4*MIN_DIGITS+12  packed BCD {min, sec_tens, sec_ones, tenth}, registered.
o_running  out  1  high while in the RUN state.
o_done  out  1  high while in the DONE state (countdown reached zero).
o_wrap  out  1  one-cycle pulse when the up-count rolls over from its maximum to zero.
i_lap, o_lap_active  exist only when STOPWATCH_LAP_EN is defined (see Optional Feature).

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - State becomes IDLE; mode register set to up.
  - Count, prescaler, o_fndcnt, o_wrap, o_done, o_running and the lap state all cleared to 0 on the next edge.
- Tick generation:
  - The prescaler counts 0..TICK_DIV-1 only while the state is RUN.
  - The tick is asserted for one cycle at TICK_DIV-1.
  - The prescaler is cleared in any other state, so the first tick after a start or resume comes a full TICK_DIV clocks later.
- States:
  - IDLE: count holds its reload value.
    - i_runstop=1 → RUN. The mode register is latched from i_mode.
    - Exception: in down mode with a preset equal to zero, the state stays IDLE.
  - RUN: i_runstop=0 → PAUSE. In down mode, a tick that reaches 00:00.0 → DONE.
  - PAUSE: count frozen. i_runstop=1 → RUN.
  - DONE: count frozen at zero, o_done=1. Ignores i_runstop and ticks. i_clear → IDLE.
- Clear and reload:
  - i_clear in any state → IDLE.
  - Count reloads to zero in up mode, or to {preset_min, preset_sec, 0} in down mode, using the latched mode.
  - In IDLE, the mode register tracks i_mode every cycle. The IDLE reload value follows it.
- Up count: on each tick, tenth 0→9 wraps to 0 and carries into seconds.
  - Seconds 00→59 wraps to 00 and carries into minutes. 59 is the last valid value; 60 never appears.
  - Minutes at maximum plus a carry → all fields 0 and o_wrap pulses. Counting continues.
- Down count: the mirror of up count (borrow chain, tenth 0→9 with borrow). Stops at 00:00.0.
- Preset sanitising: BCD digits above 9 clamp to 9; seconds tens above 5 clamps to 5.
- Latency: a count change appears on o_fndcnt one cycle after the tick cycle.
- Priority within one cycle: i_reset > i_clear > i_runstop transition > tick.
  - A tick in the same cycle that i_runstop falls is discarded.
  - The count advances only when state==RUN and i_runstop==1 in that cycle.

Optional Feature:
STOPWATCH_LAP_EN.
- Defined:
  - Adds port i_lap (in, 1, one-cycle pulse) and port o_lap_active (out, 1).
  - In RUN or PAUSE, the first i_lap captures the live count into a lap register and sets o_lap_active=1. o_fndcnt then shows the lap register while counting continues.
  - A second i_lap clears o_lap_active and returns o_fndcnt to the live count.
  - i_clear, i_reset and entry to DONE all release the lap.
- Undefined: the ports are absent and o_fndcnt always shows the live count.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding: IDLE, RUN, PAUSE, DONE;
  - BCD_W=4;
  - TENTH_MAX=9, SEC_TENS_MAX=5, SEC_ONES_MAX=9;
  - a function computing the o_fndcnt width from MIN_DIGITS.
- One sub-module: tick_gen (prescaler). Inputs i_clk, i_reset, enable; output tick pulse; parameter TICK_DIV.

Test Plan:
All scenarios use CLK_HZ=100, TICK_HZ=10 (TICK_DIV=10), MIN_DIGITS=1.
- Up count from 0:59.8, two ticks → 1:00.0. o_fndcnt=16'h1000. Seconds never read 60.
- From 9:59.9 with one tick → 0:00.0. o_wrap high for exactly one cycle; o_running stays 1.
- Down mode, preset 0:02: run 20 ticks → 0:00.0, o_done=1, state DONE. Ten more ticks cause no change. i_clear → IDLE with o_fndcnt=16'h0020.
- Run 5 ticks (0:00.5), then i_runstop=0 for 300 clocks → holds 0:00.5. On resume, the next change comes exactly 10 clocks after i_runstop rises (0:00.6).
- At 0:03.4, assert i_reset → all outputs 0 and state IDLE on the next edge. Separately, assert i_clear in the same cycle as a tick → count reloads and the tick is ignored.
- With STOPWATCH_LAP_EN: i_lap at 0:01.2, then 15 ticks → o_fndcnt=0:01.2 and o_lap_active=1. A second i_lap → o_fndcnt=0:02.7 and o_lap_active=0.
